// File: rtl/spi_pkg.sv
// spi_pkg: shared types and constants for the SPI burst sequencer.
//   spi_burst_state_t : burst FSM states
//   SPI_FILL_DEFAULT  : byte sent when no host TX data is available
//   SPI_MIN_DIV       : minimum clk count before the engine samples its byte input
package spi_pkg;
    typedef enum logic [2:0] {IDLE, PRIME, RUN, CAPTURE, DRAIN, DONE} spi_burst_state_t;
    localparam logic [7:0] SPI_FILL_DEFAULT = 8'hFF;
    localparam int SPI_MIN_DIV = 10;
endpackage

// File: rtl/spi_byte_fifo.sv
// spi_byte_fifo: synchronous show-ahead FIFO.
//   clk, rst                       : clock, synchronous active-high reset
//   in_data/in_valid/in_ready      : push side (fires on valid & ready)
//   out_data/out_valid/out_ready   : pop side, out_data is the head while out_valid
// A push is accepted when full if a pop fires in the same cycle.
module spi_byte_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      cnt_q;
    logic             push, pop;
    assign out_valid = cnt_q != '0;
    assign pop       = out_ready && out_valid;
    assign in_ready  = cnt_q != (AW+1)'(DEPTH) || pop;
    assign push      = in_valid && in_ready;
    assign out_data  = out_valid ? mem_q[rd_q] : '0;
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= in_data;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + AW'(1);
            if (pop) rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
endmodule

// File: rtl/spi_burst_ctrl.sv
// spi_burst_ctrl: burst sequencer feeding a byte-level SPI engine from a TX FIFO
// and collecting received bytes into an RX FIFO, one CS assertion per burst.
//   host TX   : tx_data, tx_valid, tx_ready
//   host RX   : rx_data, rx_valid, rx_ready
//   command   : cmd_len, cmd_msb_first, cmd_valid, cmd_ready
//   status    : busy, done (1-cycle pulse), rx_ovf (sticky, cleared on next command)
//   engine    : eng_byte_2_send, eng_byte_received, eng_new_byte, eng_ena,
//               eng_end_trans, eng_msb_lsb
// Optional macro SPI_BURST_STATS_EN adds stat_bytes (wrapping capture count) and
// stat_fill (saturating fill-byte count), both cleared only by rst.
module spi_burst_ctrl
    import spi_pkg::*;
#(
    parameter int         FIFO_DEPTH = 16,
    parameter int         LEN_W      = 8,
    parameter logic [7:0] FILL_BYTE  = SPI_FILL_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             cmd_msb_first,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    output logic             busy,
    output logic             done,
    output logic             rx_ovf,
    output logic [7:0]       eng_byte_2_send,
    input  logic [7:0]       eng_byte_received,
    input  logic             eng_new_byte,
    output logic             eng_ena,
    input  logic             eng_end_trans,
`ifdef SPI_BURST_STATS_EN
    output logic [31:0]      stat_bytes,
    output logic [15:0]      stat_fill,
`endif
    output logic             eng_msb_lsb
);
    spi_burst_state_t state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [7:0]       byte_q, byte_d;
    logic             ena_q, ena_d, msb_q, msb_d, ovf_q, ovf_d, end_q;
    logic [7:0]       tx_head;
    logic             tx_avail, tx_pop, rx_push, rx_in_ready, load, end_rise;
    logic             unused_new_byte;
    assign unused_new_byte = eng_new_byte;
    assign end_rise = eng_end_trans && !end_q;
    spi_byte_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx (
        .clk(clk), .rst(rst),
        .in_data(tx_data), .in_valid(tx_valid), .in_ready(tx_ready),
        .out_data(tx_head), .out_valid(tx_avail), .out_ready(tx_pop)
    );
    spi_byte_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx (
        .clk(clk), .rst(rst),
        .in_data(eng_byte_received), .in_valid(rx_push), .in_ready(rx_in_ready),
        .out_data(rx_data), .out_valid(rx_valid), .out_ready(rx_ready)
    );
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        byte_d  = byte_q;
        ena_d   = ena_q;
        msb_d   = msb_q;
        ovf_d   = ovf_q;
        tx_pop  = 1'b0;
        rx_push = 1'b0;
        load    = 1'b0;
        case (state_q)
            IDLE: if (cmd_valid) begin
                rem_d   = cmd_len;
                msb_d   = cmd_msb_first;
                ovf_d   = 1'b0;
                state_d = cmd_len == '0 ? DONE : PRIME;
            end
            PRIME: begin
                load    = 1'b1;
                ena_d   = 1'b1;
                state_d = RUN;
            end
            RUN: if (end_rise) state_d = CAPTURE;
            CAPTURE: begin
                rx_push = 1'b1;
                if (!rx_in_ready) ovf_d = 1'b1;
                rem_d = rem_q - LEN_W'(1);
                // ena stays high between bytes so the engine keeps CS asserted
                if (rem_d != '0) begin
                    load    = 1'b1;
                    state_d = RUN;
                end else begin
                    ena_d   = 1'b0;
                    state_d = DRAIN;
                end
            end
            DRAIN: if (!eng_end_trans) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (load) begin
            tx_pop = tx_avail;
            byte_d = tx_avail ? tx_head : FILL_BYTE;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            byte_q  <= '0;
            ena_q   <= 1'b0;
            msb_q   <= 1'b1;
            ovf_q   <= 1'b0;
            end_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            byte_q  <= byte_d;
            ena_q   <= ena_d;
            msb_q   <= msb_d;
            ovf_q   <= ovf_d;
            end_q   <= eng_end_trans;
        end
    end
    assign cmd_ready       = state_q == IDLE;
    assign busy            = state_q != IDLE;
    assign done            = state_q == DONE;
    assign rx_ovf          = ovf_q;
    assign eng_ena         = ena_q;
    assign eng_byte_2_send = byte_q;
    assign eng_msb_lsb     = msb_q;
`ifdef SPI_BURST_STATS_EN
    logic [31:0] bytes_q;
    logic [15:0] fill_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            bytes_q <= '0;
            fill_q  <= '0;
        end else begin
            if (state_q == CAPTURE) bytes_q <= bytes_q + 32'd1;
            if (load && !tx_avail && fill_q != 16'hFFFF) fill_q <= fill_q + 16'd1;
        end
    end
    assign stat_bytes = bytes_q;
    assign stat_fill  = fill_q;
`endif
endmodule
